// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-state encoding, opcode constants and datapath widths for the 8-bit CPU.
package cpu_pkg;
  localparam int DEF_PC_W    = 8;
  localparam int DEF_INSTR_W = 8;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, EXEC, HALT} fetch_state_e;
  localparam logic [3:0] OP_WAIT = 4'h0;
  localparam logic [3:0] OP_JMP6 = 4'h6;
  localparam logic [3:0] OP_JMP7 = 4'h7;
  localparam logic [3:0] OP_JMP8 = 4'h8;
  localparam logic [3:0] OP_JMPA = 4'hA;
  localparam logic [3:0] OP_STOP = 4'hF;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR owner; fetches over a req/valid handshake and applies the controller's PC decision after EXEC.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               CLB,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               IncPC,
  input  logic               LoadPC,
  input  logic               SelPC,
  input  logic [PC_W-1:0]    reg_data,
  output logic [3:0]         opcode,
  output logic [3:0]         imm,
  output logic               instr_valid,
  output logic               halted,
  output logic [PC_W-1:0]    pc,
  output logic [15:0]        instr_count
);
  fetch_state_e state_q;
  logic [PC_W-1:0] pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic [15:0] count_q;
  logic [PC_W-1:0] jump_target;
  assign jump_target = SelPC ? reg_data : {{(PC_W-4){1'b0}}, ir_q[3:0]};
  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ:  state_q <= WAIT;
        WAIT: if (imem_valid) begin
          ir_q    <= imem_rdata;
          state_q <= EXEC;
        end
        EXEC: begin
          count_q <= count_q + 16'd1;
          // LoadPC wins over IncPC; neither means STOP
          if (LoadPC) begin
            pc_q    <= jump_target;
            state_q <= REQ;
          end else if (IncPC) begin
            pc_q    <= pc_q + 1'b1;
            state_q <= REQ;
          end else state_q <= HALT;
        end
        default: state_q <= HALT;
      endcase
    end
  end
  assign imem_req    = state_q == REQ;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign opcode      = ir_q[7:4];
  assign imm         = ir_q[3:0];
  assign instr_valid = state_q == EXEC;
  assign halted      = state_q == HALT;
  assign instr_count = count_q;
endmodule
